// File: rtl/sram_rw0_march_bist.sv
// March C- built-in self-test for a single-port RW0 SRAM macro.
// Runs E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
// and reports the first mismatching read. While idle the functional request
// port passes straight through to the macro.
// Optional feature macro: SRAM_MARCH_FAILCNT_EN -- when defined the run never
// stops early and a saturating mismatch counter (fail_cnt) is provided.
// Handshake: start is a one-cycle request accepted only in IDLE or DONE;
// busy high means the macro port belongs to the test and f_en is dropped.
module sram_rw0_march_bist #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
`ifdef SRAM_MARCH_FAILCNT_EN
    output logic [15:0]       fail_cnt,
`endif
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              f_en,
    input  logic              f_wmode,
    input  logic              f_wmask,
    input  logic [DATA_W-1:0] f_wdata,
    output logic [DATA_W-1:0] f_rdata,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic              RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ONES     = '1;
    localparam logic [DATA_W-1:0] ZEROS    = '0;

    state_t              state_q;
    logic                busy_q, done_q, fail_q;
    logic [2:0]          fail_elem_q;
    logic [ADDR_W-1:0]   fail_addr_q;
    logic [DATA_W-1:0]   fail_data_q;
    logic [2:0]          elem_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                phase_q;      // 0: read half, 1: write half of a read-modify element
    logic                chk_valid_q;  // a read was issued last cycle and is compared now
    logic [DATA_W-1:0]   chk_exp_q;
    logic [ADDR_W-1:0]   chk_addr_q;
    logic [2:0]          chk_elem_q;
`ifdef SRAM_MARCH_FAILCNT_EN
    logic [15:0]         fail_cnt_q;
`endif

    logic                rm_elem, op_read, op_write, down_elem, last_addr, step;
    logic                mismatch, halt, bist_en;
    logic [ADDR_W-1:0]   next_elem_addr;
    logic [DATA_W-1:0]   bist_wdata, read_exp;

    // Decode the current march operation and the compare of last cycle's read.
    always_comb begin
        rm_elem        = (elem_q != 3'd0) && (elem_q != 3'd5);
        op_read        = (elem_q == 3'd5) || (rm_elem && !phase_q);
        op_write       = (elem_q == 3'd0) || (rm_elem && phase_q);
        down_elem      = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_addr      = down_elem ? (addr_q == '0) : (addr_q == ADDR_MAX);
        step           = !rm_elem || phase_q;
        next_elem_addr = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
        // Odd elements write ones and read zeros; even elements the opposite.
        bist_wdata     = elem_q[0] ? ONES : ZEROS;
        read_exp       = elem_q[0] ? ZEROS : ONES;
        mismatch       = chk_valid_q && (RW0_rdata != chk_exp_q);
`ifdef SRAM_MARCH_FAILCNT_EN
        halt           = 1'b0;
`else
        halt           = mismatch;
`endif
        // A detected mismatch suppresses the write that would share its cycle.
        bist_en        = (state_q == S_RUN) && (op_read || (op_write && !halt));
    end

    // Macro port mux: the test owns the port whenever busy is high.
    assign RW0_addr  = busy_q ? addr_q     : f_addr;
    assign RW0_en    = busy_q ? bist_en    : f_en;
    assign RW0_wmode = busy_q ? op_write   : f_wmode;
    assign RW0_wmask = busy_q ? 1'b1       : f_wmask;
    assign RW0_wdata = busy_q ? bist_wdata : f_wdata;
    assign f_rdata   = RW0_rdata;

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_elem = fail_elem_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`ifdef SRAM_MARCH_FAILCNT_EN
    assign fail_cnt  = fail_cnt_q;
`endif

    // Test sequencer: element/address counters, compare pipeline and result latches.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            elem_q      <= '0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
            chk_elem_q  <= '0;
`ifdef SRAM_MARCH_FAILCNT_EN
            fail_cnt_q  <= '0;
`endif
        end else begin
            if ((state_q == S_RUN || state_q == S_DRAIN) && mismatch) begin
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_elem_q <= chk_elem_q;
                    fail_addr_q <= chk_addr_q;
                    fail_data_q <= RW0_rdata;
                end
`ifdef SRAM_MARCH_FAILCNT_EN
                if (fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
`endif
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        fail_q      <= 1'b0;
                        fail_elem_q <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        elem_q      <= '0;
                        addr_q      <= '0;
                        phase_q     <= 1'b0;
                        chk_valid_q <= 1'b0;
`ifdef SRAM_MARCH_FAILCNT_EN
                        fail_cnt_q  <= '0;
`endif
                    end
                end
                S_RUN: begin
                    chk_valid_q <= op_read;
                    chk_exp_q   <= read_exp;
                    chk_addr_q  <= addr_q;
                    chk_elem_q  <= elem_q;
                    if (halt) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        chk_valid_q <= 1'b0;
                    end else begin
                        if (rm_elem) phase_q <= ~phase_q;
                        if (step) begin
                            if (last_addr) begin
                                if (elem_q == 3'd5) begin
                                    state_q <= S_DRAIN;
                                end else begin
                                    elem_q <= elem_q + 3'd1;
                                    addr_q <= next_elem_addr;
                                end
                            end else begin
                                addr_q <= down_elem ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    state_q     <= S_DONE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    chk_valid_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rw0_march_bist.sv
// Bench for sram_rw0_march_bist (ADDR_W=4, DATA_W=8) with a behavioural SRAM
// that can carry one stuck-at bit, a table of functional pass-through vectors,
// and a March C- reference model written as plain loops over an array.
module tb_sram_rw0_march_bist;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int D  = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, fail;
    logic [2:0]    fail_elem;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [15:0]   fail_cnt;
    logic [AW-1:0] f_addr = '0;
    logic          f_en = 1'b0, f_wmode = 1'b0, f_wmask = 1'b0;
    logic [DW-1:0] f_wdata = '0;
    logic [DW-1:0] f_rdata;
    logic [AW-1:0] RW0_addr;
    logic          RW0_en, RW0_wmode, RW0_wmask;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] RW0_rdata = '0;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    // SRAM model with an optional stuck-at cell bit
    logic [DW-1:0] mem[D];
    bit            fault_on = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    int            fault_bit = 0;
    bit            fault_val = 1'b0;

    sram_rw0_march_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .busy(busy), .done(done), .fail(fail),
        .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data),
`ifdef SRAM_MARCH_FAILCNT_EN
        .fail_cnt(fail_cnt),
`endif
        .f_addr(f_addr), .f_en(f_en), .f_wmode(f_wmode), .f_wmask(f_wmask),
        .f_wdata(f_wdata), .f_rdata(f_rdata),
        .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    // clock / reset block
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (fault_on && a == fault_addr) r[fault_bit] = fault_val;
        return r;
    endfunction

    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                if (RW0_wmask) mem[RW0_addr] <= RW0_wdata;
            end else begin
                RW0_rdata <= faulty(RW0_addr, mem[RW0_addr]);
            end
        end
    end

    task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Reference: walk March C- over an array; cycle numbers count from 1 after the start edge.
    task automatic model_run(output int done_cyc, output bit f, output int fe, output int fa,
                             output int fd, output int cnt);
        logic [DW-1:0] m[D];
        logic [DW-1:0] v, rexp, wval;
        int cyc, a;
        cyc = 0; f = 0; fe = 0; fa = 0; fd = 0; cnt = 0;
        done_cyc = 10 * D + 2;
        for (int i = 0; i < D; i++) begin
            cyc++;
            m[i] = '0;
        end
        for (int e = 1; e <= 5; e++) begin
            rexp = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            wval = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int i = 0; i < D; i++) begin
                a = (e == 3 || e == 4) ? (D - 1 - i) : i;
                cyc++;
                v = faulty(AW'(a), m[a]);
                if (v != rexp) begin
                    cnt++;
                    if (!f) begin
                        f = 1; fe = e; fa = a; fd = int'(v);
`ifndef SRAM_MARCH_FAILCNT_EN
                        done_cyc = cyc + 2;
                        return;
`endif
                    end
                end
                if (e != 5) begin
                    cyc++;
                    m[a] = wval;
                end
            end
        end
    endtask

    // driver: one full run from IDLE/DONE, compared against the model
    task automatic run_check(input string tag, input bit noise);
        int exp_done, exp_fe, exp_fa, exp_fd, exp_cnt, n, bad;
        bit exp_f;
        model_run(exp_done, exp_f, exp_fe, exp_fa, exp_fd, exp_cnt);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        check(tag, "busy_first", busy, 1);
        check(tag, "done_cleared", done, 0);
        check(tag, "fail_cleared", {fail, fail_addr, fail_data}, 0);
        bad = 0;
        while (!done && n < 4000) begin
            if (noise) begin
                f_en    = 1'($urandom_range(0, 1));
                f_wmode = 1'($urandom_range(0, 1));
                f_wmask = 1'b1;
                f_addr  = AW'($urandom_range(0, D - 1));
                f_wdata = DW'($urandom);
                start   = ($urandom_range(0, 7) == 0);
            end
            @(negedge clock);
            n++;
            if (!done && !busy) bad++;
        end
        start = 1'b0;
        f_en  = 1'b0;
        check(tag, "done_cycle", n, exp_done);
        check(tag, "busy_gaps", bad, 0);
        check(tag, "busy_end", busy, 0);
        check(tag, "fail", fail, exp_f);
        check(tag, "fail_elem", fail_elem, exp_fe);
        check(tag, "fail_addr", fail_addr, exp_fa);
        check(tag, "fail_data", fail_data, exp_fd);
`ifdef SRAM_MARCH_FAILCNT_EN
        check(tag, "fail_cnt", fail_cnt, exp_cnt);
`endif
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          en, wmode, wmask;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd_exp;
    } vec_t;

    vec_t vecs[8];
    logic [DW-1:0] shadow[D];

    // driver: one functional request while idle; checks the mux and last read data
    task automatic func_op(input string tag, input vec_t v);
        @(negedge clock);
        if (exp_q.size() > 0) check(tag, "f_rdata", f_rdata, exp_q.pop_front());
        f_addr = v.addr; f_en = v.en; f_wmode = v.wmode; f_wmask = v.wmask; f_wdata = v.wdata;
        #1;
        check(tag, "mux", {RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata},
              {v.addr, v.en, v.wmode, v.wmask, v.wdata});
        if (v.en && !v.wmode) exp_q.push_back(v.rd_exp);
    endtask

    initial begin
        vec_t rv;
        int n;
        for (int i = 0; i < D; i++) mem[i] = '0;

        vecs[0] = '{addr: 4'd3, en: 1, wmode: 1, wmask: 1, wdata: 8'hA5, rd_exp: 8'h00};
        vecs[1] = '{addr: 4'd3, en: 1, wmode: 0, wmask: 0, wdata: 8'h00, rd_exp: 8'hA5};
        vecs[2] = '{addr: 4'd7, en: 1, wmode: 1, wmask: 1, wdata: 8'h3C, rd_exp: 8'h00};
        vecs[3] = '{addr: 4'd7, en: 1, wmode: 0, wmask: 0, wdata: 8'h00, rd_exp: 8'h3C};
        vecs[4] = '{addr: 4'd7, en: 1, wmode: 1, wmask: 0, wdata: 8'hFF, rd_exp: 8'h00};
        vecs[5] = '{addr: 4'd7, en: 1, wmode: 0, wmask: 0, wdata: 8'h00, rd_exp: 8'h3C};
        vecs[6] = '{addr: 4'd3, en: 0, wmode: 1, wmask: 1, wdata: 8'h00, rd_exp: 8'h00};
        vecs[7] = '{addr: 4'd3, en: 1, wmode: 0, wmask: 0, wdata: 8'h00, rd_exp: 8'hA5};

        // reset
        repeat (3) @(negedge clock);
        check("reset", "busy_done_fail", {busy, done, fail}, 0);
        check("reset", "fail_info", {fail_elem, fail_addr, fail_data}, 0);
        reset_n = 1'b1;

        // functional pass-through while idle: fixed table, then random ops
        for (int i = 0; i < 8; i++) func_op("table", vecs[i]);
        for (int i = 0; i < D; i++) begin
            rv = '{addr: AW'(i), en: 1, wmode: 1, wmask: 1, wdata: DW'($urandom), rd_exp: 8'h00};
            shadow[i] = rv.wdata;
            func_op("rand_fill", rv);
        end
        for (int i = 0; i < 40; i++) begin
            rv.addr  = AW'($urandom_range(0, D - 1));
            rv.en    = 1'b1;
            rv.wmode = 1'($urandom_range(0, 1));
            rv.wmask = 1'($urandom_range(0, 1));
            rv.wdata = DW'($urandom);
            rv.rd_exp = shadow[rv.addr];
            if (rv.wmode && rv.wmask) shadow[rv.addr] = rv.wdata;
            func_op("rand_func", rv);
        end
        rv = '{addr: 4'd0, en: 0, wmode: 0, wmask: 0, wdata: 8'h00, rd_exp: 8'h00};
        func_op("rand_func", rv);

        // fault-free run, then a run with start pulses and functional traffic while busy
        run_check("t1", 1'b0);
        run_check("t5", 1'b1);

        // stuck-at-1 on bit 3 of address 5
        fault_on = 1'b1; fault_addr = 4'd5; fault_bit = 3; fault_val = 1'b1;
        run_check("t2", 1'b0);
        check("t2", "fail_elem_const", fail_elem, 1);
        check("t2", "fail_addr_const", fail_addr, 5);
        check("t2", "fail_data_const", fail_data, 8'h08);
`ifdef SRAM_MARCH_FAILCNT_EN
        check("t3", "fail_cnt_const", fail_cnt, 3);
`else
        check("t2", "no_write_at_fail", mem[5], 8'h00);
        check("t2", "e1_writes_before", mem[4], 8'hFF);
        check("t2", "no_e2_writes", mem[0], 8'hFF);
`endif

        // random single stuck-at faults
        for (int r = 0; r < 6; r++) begin
            fault_addr = AW'($urandom_range(0, D - 1));
            fault_bit  = $urandom_range(0, DW - 1);
            fault_val  = 1'($urandom_range(0, 1));
            run_check("rand_fault", 1'(r & 1));
        end
        fault_on = 1'b0;

        // reset mid-run, then a full clean run
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (n < 50) begin
            @(negedge clock);
            n++;
        end
        reset_n = 1'b0;
        @(negedge clock);
        check("t6", "abort_state", {busy, done, fail}, 0);
        reset_n = 1'b1;
        run_check("t6_rerun", 1'b0);

        // reset and start in the same cycle: reset wins
        reset_n = 1'b0;
        start   = 1'b1;
        @(negedge clock);
        check("rst_start", "busy_done", {busy, done}, 0);
        reset_n = 1'b1;
        start   = 1'b0;
        @(negedge clock);
        check("rst_start", "stays_idle", {busy, done}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
